alarm_timer: RTL



---
 rtl/alarm_timer_pkg.sv | 21 ++
 rtl/alarm_timer_if.sv | 25 ++
 rtl/alarm_timer_time_param_bank.sv | 45 ++++
 rtl/alarm_timer.sv | 106 ++++++++++
 4 files changed

// File: rtl/alarm_timer_pkg.sv
// Shared constants for the alarm timing stage: interval codes, default
// delays in seconds and the countdown state encoding.
`timescale 1ns/1ps
package alarm_pkg;

  localparam logic [1:0] INT_ARM       = 2'd0;
  localparam logic [1:0] INT_DRIVER    = 2'd1;
  localparam logic [1:0] INT_PASSENGER = 2'd2;
  localparam logic [1:0] INT_ALARM_ON  = 2'd3;

  localparam logic [3:0] T_ARM_DELAY_DEFAULT = 4'd6;
  localparam logic [3:0] T_DRIVER_DEFAULT    = 4'd8;
  localparam logic [3:0] T_PASSENGER_DEFAULT = 4'd15;
  localparam logic [3:0] T_ALARM_ON_DEFAULT  = 4'd10;

  typedef enum logic {
    CD_IDLE = 1'b0,
    CD_RUN  = 1'b1
  } cd_state_e;

endpackage

// File: rtl/alarm_timer_if.sv
// Link between the alarm control FSM (master) and the timing stage (slave).
`timescale 1ns/1ps
interface alarm_timer_if;

  logic       start_timer;
  logic [1:0] interval;
  logic       reprogram;
  logic [1:0] time_param_sel;
  logic [3:0] time_value;
  logic       one_hz_enable;
  logic       blink;
  logic       expired;
  logic [3:0] count_display;

  modport master (
    output start_timer, interval, reprogram, time_param_sel, time_value,
    input  one_hz_enable, blink, expired, count_display
  );

  modport slave (
    input  start_timer, interval, reprogram, time_param_sel, time_value,
    output one_hz_enable, blink, expired, count_display
  );

endinterface

// File: rtl/alarm_timer_time_param_bank.sv
// Four reprogrammable delay slots; writing 0 restores the slot's default,
// so a slot never holds 0.
`timescale 1ns/1ps
module time_param_bank
  import alarm_pkg::*;
#(
  parameter logic [3:0] T_ARM_DELAY_DEF = T_ARM_DELAY_DEFAULT,
  parameter logic [3:0] T_DRIVER_DEF    = T_DRIVER_DEFAULT,
  parameter logic [3:0] T_PASSENGER_DEF = T_PASSENGER_DEFAULT,
  parameter logic [3:0] T_ALARM_ON_DEF  = T_ALARM_ON_DEFAULT
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       reprogram_i,
  input  logic [1:0] writeSel_i,
  input  logic [3:0] writeValue_i,
  input  logic [1:0] readSel_i,
  output logic [3:0] readValue_o
);

  logic [3:0] slot_q [4];

  function automatic logic [3:0] defaultFor(input logic [1:0] sel);
    case (sel)
      INT_ARM:       return T_ARM_DELAY_DEF;
      INT_DRIVER:    return T_DRIVER_DEF;
      INT_PASSENGER: return T_PASSENGER_DEF;
      default:       return T_ALARM_ON_DEF;
    endcase
  endfunction

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        slot_q[i] <= defaultFor(2'(i));
      end
    end else if (reprogram_i) begin
      slot_q[writeSel_i] <= (writeValue_i == 4'd0) ? defaultFor(writeSel_i)
                                                   : writeValue_i;
    end
  end

  assign readValue_o = slot_q[readSel_i];

endmodule

// File: rtl/alarm_timer.sv
// Timing stage for the alarm FSM: 1 Hz prescaler, blink square wave,
// parameter bank and a seconds countdown that pulses expired at zero.
`timescale 1ns/1ps
module alarm_timer
  import alarm_pkg::*;
#(
  parameter int         CLK_HZ          = 50_000_000,
  parameter logic [3:0] T_ARM_DELAY_DEF = T_ARM_DELAY_DEFAULT,
  parameter logic [3:0] T_DRIVER_DEF    = T_DRIVER_DEFAULT,
  parameter logic [3:0] T_PASSENGER_DEF = T_PASSENGER_DEFAULT,
  parameter logic [3:0] T_ALARM_ON_DEF  = T_ALARM_ON_DEFAULT
) (
  input  logic             clock,
  input  logic             reset,
  alarm_timer_if.slave     bus
);

  localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_HZ - 1);

  logic [PW-1:0] presc_q, presc_d;
  logic          oneHz_q, oneHz_d;
  logic          blink_q, blink_d;
  logic          expired_q, expired_d;
  logic [3:0]    remaining_q, remaining_d;
  cd_state_e     state_q, state_d;
  logic          clearPresc;
  logic [3:0]    loadValue;

  time_param_bank #(
    .T_ARM_DELAY_DEF (T_ARM_DELAY_DEF),
    .T_DRIVER_DEF    (T_DRIVER_DEF),
    .T_PASSENGER_DEF (T_PASSENGER_DEF),
    .T_ALARM_ON_DEF  (T_ALARM_ON_DEF)
  ) paramBank (
    .clock        (clock),
    .reset        (reset),
    .reprogram_i  (bus.reprogram),
    .writeSel_i   (bus.time_param_sel),
    .writeValue_i (bus.time_value),
    .readSel_i    (bus.interval),
    .readValue_o  (loadValue)
  );

  // Reprogram aborts and outranks start; a start outranks a coincident tick.
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    expired_d   = 1'b0;
    clearPresc  = 1'b0;
    if (bus.reprogram) begin
      state_d     = CD_IDLE;
      remaining_d = 4'd0;
      clearPresc  = 1'b1;
    end else if (bus.start_timer) begin
      state_d     = CD_RUN;
      remaining_d = loadValue;
      clearPresc  = 1'b1;
    end else if (state_q == CD_RUN && oneHz_q) begin
      if (remaining_q > 4'd1) begin
        remaining_d = remaining_q - 4'd1;
      end else begin
        remaining_d = 4'd0;
        expired_d   = 1'b1;
        state_d     = CD_IDLE;
      end
    end
  end

  // A restart also kills any pending tick so the first second is a full one.
  always_comb begin
    presc_d = presc_q;
    oneHz_d = 1'b0;
    if (clearPresc) begin
      presc_d = '0;
    end else begin
      presc_d = (presc_q == PRESC_MAX) ? '0 : presc_q + PW'(1);
      oneHz_d = (presc_q == PRESC_MAX);
    end
    blink_d = blink_q ^ oneHz_d;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      presc_q     <= '0;
      oneHz_q     <= 1'b0;
      blink_q     <= 1'b0;
      expired_q   <= 1'b0;
      remaining_q <= 4'd0;
      state_q     <= CD_IDLE;
    end else begin
      presc_q     <= presc_d;
      oneHz_q     <= oneHz_d;
      blink_q     <= blink_d;
      expired_q   <= expired_d;
      remaining_q <= remaining_d;
      state_q     <= state_d;
    end
  end

  assign bus.one_hz_enable = oneHz_q;
  assign bus.blink         = blink_q;
  assign bus.expired       = expired_q;
  assign bus.count_display = remaining_q;

endmodule
